// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one operand bit per clock, LSB first, one borrow flip-flop.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed Overflow output.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
  logic [CW-1:0]    cnt;
  logic             borrow, diff_bit, borrow_next;
  logic             load, last_bit;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb, b_msb;
`endif

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign load     = (state != RUN) && start;
  assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));

  assign diff_bit    = a_sh[0] ^ b_sh[0] ^ borrow;
  assign borrow_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    res_next            = res_sh >> 1;
    res_next[WIDTH-1]   = diff_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      borrow     <= 1'b0;
      Diff       <= '0;
      Borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      Overflow   <= 1'b0;
`endif
    end else if (load) begin
      a_sh   <= A;
      b_sh   <= B;
      res_sh <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      // Operand sign bits are shifted out during RUN, so keep them for the overflow test.
      a_msb  <= A[WIDTH-1];
      b_msb  <= B[WIDTH-1];
`endif
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next;
      borrow <= borrow_next;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        Diff       <= res_next;
        Borrow_out <= borrow_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
        Overflow   <= (a_msb != b_msb) && (diff_bit != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus random
// operands checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic             busy, done, Borrow_out;
  logic [WIDTH-1:0] Diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             Overflow;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .Diff       (Diff),
    .Borrow_out (Borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .Overflow   (Overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer subtraction, unsigned compare and signed range test.
  task automatic checkResult(input string tag, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    checkOutput({tag, "_diff"},   32'(Diff),       32'((ua - ub) & 255));
    checkOutput({tag, "_borrow"}, 32'(Borrow_out), 32'(ua < ub));
`ifdef SERIAL_SUB_OVERFLOW_EN
    checkOutput({tag, "_ovf"},    32'(Overflow),   32'(((sa - sb) > 127) || ((sa - sb) < -128)));
`else
    if (sa == sb) n_compared += 0;
`endif
  endtask

  // Starts one operation from IDLE/DONE, scrambles A/B during RUN, checks latency and result.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] prev_diff;
    int         done_at;
    prev_diff = Diff;
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_at = -1;
    for (int j = 0; j < WIDTH + 3 && done_at < 0; j++) begin
      A = 8'($urandom);
      B = 8'($urandom);
      if (done) done_at = j;
      else begin
        checkOutput("busy_in_run", 32'(busy), 32'd1);
        checkOutput("diff_hold",   32'(Diff), 32'(prev_diff));
        @(negedge clk);
      end
    end
    checkOutput("latency", 32'(done_at), 32'(WIDTH));
    checkResult("op", a, b);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("busy_after",     32'(busy), 32'd0);
  endtask

  initial begin
    int pulses, first_done, gap;
    logic [7:0] edge_a [6] = '{8'hFF, 8'h00, 8'h7F, 8'h80, 8'h00, 8'hFF};
    logic [7:0] edge_b [6] = '{8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h00, 8'hFF};

    reset = 1'b1;
    start = 1'b1;
    A = 8'hAA;
    B = 8'h11;
    repeat (3) @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy",   32'(busy),       32'd0);
    checkOutput("reset_done",   32'(done),       32'd0);
    checkOutput("reset_diff",   32'(Diff),       32'd0);
    checkOutput("reset_borrow", 32'(Borrow_out), 32'd0);

    applyStimulus(8'h05, 8'h03);
    applyStimulus(8'h03, 8'h05);
    applyStimulus(8'h80, 8'h01);

    // A start pulse during RUN must be ignored and produce no extra done.
    A = 8'h10;
    B = 8'h01;
    start = 1'b1;
    pulses = 0;
    first_done = -1;
    for (int j = -1; j < WIDTH + 4; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == 1) begin
        start = 1'b1;
        A = 8'hFF;
        B = 8'h00;
      end
      if (done) begin
        pulses++;
        if (first_done < 0) first_done = j + 1;
      end
    end
    checkOutput("ignored_start_pulses",  32'(pulses),     32'd1);
    checkOutput("ignored_start_latency", 32'(first_done), 32'(WIDTH));
    checkResult("ignored_start", 8'h10, 8'h01);

    // Reset in the middle of RUN aborts without a done pulse.
    A = 8'h5A;
    B = 8'h33;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy",   32'(busy),       32'd0);
    checkOutput("abort_done",   32'(done),       32'd0);
    checkOutput("abort_diff",   32'(Diff),       32'd0);
    checkOutput("abort_borrow", 32'(Borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    checkOutput("abort_ovf",    32'(Overflow),   32'd0);
`endif
    pulses = 0;
    for (int j = 0; j < WIDTH + 2; j++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 32'(pulses), 32'd0);
    applyStimulus(8'h00, 8'h00);

    // Back-to-back: start held while DONE launches the next run immediately.
    A = 8'h20;
    B = 8'h07;
    start = 1'b1;
    first_done = -1;
    for (int j = 0; j < WIDTH + 3 && first_done < 0; j++) begin
      @(negedge clk);
      if (done) first_done = j;
    end
    checkOutput("b2b_first_latency", 32'(first_done), 32'(WIDTH));
    checkResult("b2b_first", 8'h20, 8'h07);
    A = 8'h09;
    B = 8'h0A;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_done_low", 32'(done), 32'd0);
    checkOutput("b2b_busy",     32'(busy), 32'd1);
    gap = 1;
    while (!done && gap < WIDTH + 4) begin
      @(negedge clk);
      gap++;
    end
    checkOutput("b2b_gap", 32'(gap), 32'(WIDTH + 1));
    checkResult("b2b_second", 8'h09, 8'h0A);
    @(negedge clk);

    for (int i = 0; i < 6; i++) applyStimulus(edge_a[i], edge_b[i]);
    for (int i = 0; i < 24; i++) applyStimulus(8'($urandom), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
